clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period and high time of a slow, asynchronous square-wave input in i_clk cycles, and reports whether the input is stable. It is the checking side of the clock divider. It sits downstream of divided-clock outputs, or of external reference pins. It gives firmware and self-test logic a measured value to compare against the configured divide ratio.

## Interface
- P_CNT_W, 16, width of the period/high counters and outputs (8..32)
- P_TIMEOUT, 65535, count at which a missing rising edge is declared a timeout (2..2^P_CNT_W-1)
- P_TOL, 0, maximum |difference| between consecutive periods for lock
- i_clk  in  1  measurement clock
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  measurement enable; low forces IDLE
- i_sig  in  1  asynchronous input signal to measure
- o_period  out  P_CNT_W  last measured period, in i_clk cycles
- o_high  out  P_CNT_W  last measured high time, in i_clk cycles
- o_valid  out  1  one-cycle pulse when o_period/o_high update
- o_locked  out  1  two consecutive periods within P_TOL
- o_timeout  out  1  sticky; no rising edge within P_TIMEOUT cycles

## Operation
- Input path:
  - i_sig passes through a 2-FF synchronizer, then a third register for edge detection.
  - Rise = sync_q & ~edge_q. Fall = ~sync_q & edge_q.
- All registers reset asynchronously on i_rst. All outputs reset to 0. The FSM resets to IDLE.
- State machine:
  - IDLE: counter held at 0. Go to WAIT_RISE when i_en=1.
  - WAIT_RISE: on rise, cnt<=1 and go to MEASURE.
  - MEASURE:
    - Normal cycle: cnt<=cnt+1 each cycle.
    - On fall: high_cap<=cnt.
    - On rise:
      - o_period<=cnt and o_high<=high_cap.
      - o_valid<=1, o_timeout<=0, cnt<=1.
      - Stay in MEASURE.
    - If cnt==P_TIMEOUT and no rise this cycle:
      - o_timeout<=1, o_locked<=0.
      - Go to WAIT_RISE. The counter does not wrap.
  - Any state, i_en=0: go to IDLE next cycle.
    - Clears o_locked, the prev-valid flag and cnt.
    - o_period, o_high and o_timeout hold their values.
- Lock:
  - A prev_period register and a prev_ok flag are kept.
  - On each valid: o_locked<=prev_ok & (|o_period_new − prev_period| ≤ P_TOL); then prev_period<=new value and prev_ok<=1.
  - The first measurement after WAIT_RISE, IDLE or timeout never sets lock.
  - The difference is computed in P_CNT_W+1 bits, unsigned magnitude.
- Rise and fall in the same cycle cannot occur; this follows from the edge-detector construction.
- A rise in the same cycle that cnt==P_TIMEOUT counts as a valid measurement, not a timeout.
- The measured signal must hold each phase ≥1 i_clk cycle after synchronization. Narrower async pulses may be missed; this is not an error condition.

## Timing
- Sync latency: rise/fall detection occurs 3 i_clk edges after the input transition.
- For a synchronous input with period N and high H: o_period=N and o_high=H exactly, with no ±1 error.
- o_valid asserts on the cycle after the second detected rise. Outputs are registered and update in the same cycle as o_valid.
- o_valid is exactly 1 cycle wide. Consecutive pulses are N cycles apart.
- o_locked and o_timeout update in the same cycle as o_valid, or on the timeout cycle.
- Minimum measurable period: 2 cycles (high 1, low 1).
- i_rst mid-measurement: all outputs go to 0 immediately. The measurement restarts from WAIT_RISE once i_rst deasserts and i_en=1.

## Test plan
- Drive i_sig from the clock divider with P_CLK_DIV_CNT=4, i_en=1:
  - First o_valid gives o_period=4, o_high=2, o_locked=0.
  - The second o_valid gives o_locked=1.
  - o_valid pulses recur every 4 cycles.
- Synchronous i_sig with period 10, high 3:
  - o_period=10 and o_high=3.
  - Switch to period 12: o_locked drops to 0 at that valid, then returns to 1 at the next.
  - Repeat with P_TOL=2: o_locked stays 1 through the switch.
- Hold i_sig low after lock, with P_TIMEOUT=20:
  - o_timeout=1 and o_locked=0 exactly 20 cycles after the last counted rise.
  - o_period is held.
  - Resume toggling: o_timeout clears at the next o_valid.
- Minimum period, i_sig toggling every cycle: o_period=2 and o_high=1 on every valid.
- Deassert i_en mid-period, then reassert: no o_valid until two fresh rises are seen, and o_locked=0 until the second valid.
- Assert i_rst asynchronously mid-measurement: all outputs are 0 before the next i_clk edge, and measurement recovers as in the first scenario.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in i_clk cycles,
// and reports lock (consecutive periods agree) and a sticky missing-edge timeout.
module clk_period_meter #(
    parameter int unsigned P_CNT_W   = 16,
    parameter int unsigned P_TIMEOUT = 65535,
    parameter int unsigned P_TOL     = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_sig,
    output logic [P_CNT_W-1:0] o_period,
    output logic [P_CNT_W-1:0] o_high,
    output logic               o_valid,
    output logic               o_locked,
    output logic               o_timeout
);

    localparam logic [P_CNT_W-1:0] LP_TIMEOUT = P_CNT_W'(P_TIMEOUT);
    localparam logic [P_CNT_W:0]   LP_TOL     = (P_CNT_W+1)'(P_TOL);
    localparam logic [P_CNT_W-1:0] LP_ONE     = P_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RISE,
        S_MEASURE
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic               r_sync1, r_sync2, r_edge;
    logic               w_rise, w_fall;
    logic [P_CNT_W-1:0] r_cnt, r_high_cap, r_prev_period, r_period, r_high;
    logic               r_prev_ok, r_valid, r_locked, r_timeout;
    logic [P_CNT_W-1:0] w_cnt_n, w_high_cap_n, w_prev_period_n, w_period_n, w_high_n;
    logic               w_prev_ok_n, w_valid_n, w_locked_n, w_timeout_n;
    logic [P_CNT_W:0]   w_cur, w_prv, w_diff;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_edge;
    assign w_fall = ~r_sync2 & r_edge;

    // Unsigned magnitude of the period change, one bit wider so it cannot overflow.
    assign w_cur  = {1'b0, r_cnt};
    assign w_prv  = {1'b0, r_prev_period};
    assign w_diff = (w_cur >= w_prv) ? (w_cur - w_prv) : (w_prv - w_cur);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_cnt_n         = r_cnt;
        w_high_cap_n    = r_high_cap;
        w_prev_period_n = r_prev_period;
        w_prev_ok_n     = r_prev_ok;
        w_period_n      = r_period;
        w_high_n        = r_high;
        w_valid_n       = 1'b0;
        w_locked_n      = r_locked;
        w_timeout_n     = r_timeout;
        if (!i_en) begin
            w_state_n   = S_IDLE;
            w_cnt_n     = '0;
            w_locked_n  = 1'b0;
            w_prev_ok_n = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_n   = '0;
                    w_state_n = S_WAIT_RISE;
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        w_cnt_n   = LP_ONE;
                        w_state_n = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_fall) begin
                        w_high_cap_n = r_cnt;
                    end
                    // A rise on the timeout count still wins as a valid measurement.
                    if (w_rise) begin
                        w_period_n      = r_cnt;
                        w_high_n        = r_high_cap;
                        w_valid_n       = 1'b1;
                        w_timeout_n     = 1'b0;
                        w_cnt_n         = LP_ONE;
                        w_locked_n      = r_prev_ok && (w_diff <= LP_TOL);
                        w_prev_period_n = r_cnt;
                        w_prev_ok_n     = 1'b1;
                    end else if (r_cnt == LP_TIMEOUT) begin
                        w_timeout_n = 1'b1;
                        w_locked_n  = 1'b0;
                        w_prev_ok_n = 1'b0;
                        w_state_n   = S_WAIT_RISE;
                    end else begin
                        w_cnt_n = r_cnt + LP_ONE;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt         <= '0;
            r_high_cap    <= '0;
            r_prev_period <= '0;
            r_prev_ok     <= 1'b0;
            r_period      <= '0;
            r_high        <= '0;
            r_valid       <= 1'b0;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_n;
            r_high_cap    <= w_high_cap_n;
            r_prev_period <= w_prev_period_n;
            r_prev_ok     <= w_prev_ok_n;
            r_period      <= w_period_n;
            r_high        <= w_high_n;
            r_valid       <= w_valid_n;
            r_locked      <= w_locked_n;
            r_timeout     <= w_timeout_n;
        end
    end

    assign o_period  = r_period;
    assign o_high    = r_high;
    assign o_valid   = r_valid;
    assign o_locked  = r_locked;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: two instances (tolerance 0 and 2) share one
// synchronous stimulus; expected measurements are queued when each rise is driven.
module tb_clk_period_meter;

    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          sigIn;
    logic [CW-1:0] period0, high0, period1, high1;
    logic          valid0, locked0, timeout0, valid1, locked1, timeout1;

    typedef struct {
        int unsigned period;
        int unsigned high;
        bit          locked;
        bit          gapChk;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          failures = 0;
    int          cycleCount = 0;
    int          lastValid[2];
    bit          armed;
    bit          prevOk;
    int unsigned lastN, lastH, prevP;
    int          timeoutCycle;

    clk_period_meter #(.P_CNT_W(CW), .P_TIMEOUT(20), .P_TOL(0)) dut0 (
        .i_clk(clock), .i_rst(reset), .i_en(enable), .i_sig(sigIn),
        .o_period(period0), .o_high(high0), .o_valid(valid0),
        .o_locked(locked0), .o_timeout(timeout0)
    );

    clk_period_meter #(.P_CNT_W(CW), .P_TIMEOUT(20), .P_TOL(2)) dut1 (
        .i_clk(clock), .i_rst(reset), .i_en(enable), .i_sig(sigIn),
        .o_period(period1), .o_high(high1), .o_valid(valid1),
        .o_locked(locked1), .o_timeout(timeout1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkValid(input int d, input logic [CW-1:0] p, input logic [CW-1:0] h,
                              input logic l, input logic t);
        exp_t  e;
        string pre;
        pre = (d == 0) ? "dut0" : "dut1";
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checkOutput({pre, " unexpected valid"}, 64'd1, 64'd0);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        checkOutput({pre, " period"}, 64'(p), 64'(e.period));
        checkOutput({pre, " high"}, 64'(h), 64'(e.high));
        checkOutput({pre, " locked"}, 64'(l), 64'(e.locked));
        checkOutput({pre, " timeout at valid"}, 64'(t), 64'd0);
        if (e.gapChk) checkOutput({pre, " valid spacing"}, 64'(cycleCount - lastValid[d]), 64'(e.period));
        lastValid[d] = cycleCount;
    endtask

    always @(negedge clock) begin
        if (valid0) checkValid(0, period0, high0, locked0, timeout0);
        if (valid1) checkValid(1, period1, high1, locked1, timeout1);
    end

    task automatic pushExp(input int unsigned n, input int unsigned h);
        exp_t        e;
        int unsigned diff;
        diff     = (n > prevP) ? (n - prevP) : (prevP - n);
        e.period = n;
        e.high   = h;
        e.gapChk = prevOk;
        e.locked = prevOk && (diff == 0);
        q0.push_back(e);
        e.locked = prevOk && (diff <= 2);
        q1.push_back(e);
        prevOk = 1'b1;
        prevP  = n;
    endtask

    task automatic disarm();
        armed  = 1'b0;
        prevOk = 1'b0;
    endtask

    // Drives one period starting with a rise; that rise completes the previous period.
    task automatic applyStimulus(input int unsigned n, input int unsigned h);
        if (armed) pushExp(lastN, lastH);
        armed = 1'b1;
        lastN = n;
        lastH = h;
        sigIn = 1'b1;
        repeat (h) @(posedge clock);
        #1 sigIn = 1'b0;
        repeat (n - h) @(posedge clock);
        #1;
    endtask

    task automatic runPeriods(input int unsigned n, input int unsigned h, input int count);
        for (int i = 0; i < count; i++) applyStimulus(n, h);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        sigIn  = 1'b0;
        armed  = 1'b0;
        prevOk = 1'b0;
        prevP  = 0;
        lastValid[0] = 0;
        lastValid[1] = 0;
        #2 reset = 1'b1;
        #1;
        checkOutput("reset period", 64'(period0), 64'd0);
        checkOutput("reset high", 64'(high0), 64'd0);
        checkOutput("reset valid", 64'(valid0), 64'd0);
        checkOutput("reset locked", 64'(locked0), 64'd0);
        checkOutput("reset timeout", 64'(timeout0), 64'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        enable = 1'b1;

        runPeriods(4, 2, 6);
        runPeriods(10, 3, 4);
        runPeriods(12, 3, 3);
        runPeriods(10, 3, 3);

        for (int k = 0; k < 60 && !timeout0; k++) @(negedge clock);
        timeoutCycle = cycleCount;
        checkOutput("timeout asserted", 64'(timeout0), 64'd1);
        checkOutput("timeout delay", 64'(timeoutCycle - lastValid[0]), 64'd20);
        checkOutput("timeout locked", 64'(locked0), 64'd0);
        checkOutput("timeout period held", 64'(period0), 64'd10);
        checkOutput("timeout tol2", 64'(timeout1), 64'd1);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("timeout sticky", 64'(timeout0), 64'd1);
        disarm();

        runPeriods(10, 3, 3);
        checkOutput("timeout cleared", 64'(timeout0), 64'd0);
        runPeriods(2, 1, 8);
        runPeriods(10, 3, 2);

        enable = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("disable locked", 64'(locked0), 64'd0);
        checkOutput("disable period held", 64'(period0), 64'd10);
        enable = 1'b1;
        disarm();
        runPeriods(4, 2, 4);
        runPeriods(10, 3, 2);

        checkOutput("queue before reset", 64'(q0.size() + q1.size()), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("async reset period", 64'(period0), 64'd0);
        checkOutput("async reset high", 64'(high0), 64'd0);
        checkOutput("async reset locked", 64'(locked0), 64'd0);
        checkOutput("async reset tol2 locked", 64'(locked1), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        disarm();
        runPeriods(4, 2, 5);

        repeat (10) @(posedge clock);
        #1;
        checkOutput("queue drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
